// File: rtl/ex_mem_buf.sv
// ex_mem_buf: EX/MEM pipeline stage built as a 2-entry elastic (skid) buffer.
//
// EX hands instructions in with a valid/ready handshake. MEM takes them out
// with a second valid/ready handshake. The head entry (H) is always the older
// entry. The skid entry (S) holds the younger entry while MEM is back-pressuring.
// Both entries are exposed as forwarding taps, so ID/EX can bypass results
// that are still sitting in the buffer.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global run enable; low freezes all state
//   flush              synchronous clear of both entries (overrides rdy)
//   in_valid/in_ready  EX-side handshake
//   ex_* / *_i         incoming instruction fields
//   out_valid/out_ready MEM-side handshake
//   mem_* / *_o        head-entry fields, driven straight from flops
//   count              occupancy, 0..2
//   fwd0_* / fwd1_*    head / skid forwarding taps (combinational decode)
module ex_mem_buf #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LEN_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [DATA_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_write_data_i,
  input  logic [LEN_W-1:0]      mem_length_i,
  input  logic                  mem_signed_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  load_o,
  output logic                  store_o,
  output logic [DATA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_write_data_o,
  output logic [LEN_W-1:0]      mem_length_o,
  output logic                  mem_signed_o,
  output logic [1:0]            count,
  output logic                  fwd0_valid,
  output logic [REG_ADDR_W-1:0] fwd0_wd,
  output logic [DATA_W-1:0]     fwd0_data,
  output logic                  fwd0_load,
  output logic                  fwd1_valid,
  output logic [REG_ADDR_W-1:0] fwd1_wd,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic                  fwd1_load
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  load;
    logic                  store;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [LEN_W-1:0]      len;
    logic                  sgn;
  } entry_t;

  entry_t h_q;
  entry_t s_q;
  entry_t in_e;
  logic   acc;
  logic   deq;

  assign in_ready = rdy && (count < 2'd2);
  assign acc      = in_valid && in_ready;
  assign deq      = h_q.valid && out_ready && rdy;

  always_comb begin
    in_e         = '0;
    in_e.valid   = 1'b1;
    in_e.wd      = ex_wd;
    in_e.wreg    = ex_wreg;
    in_e.wdata   = ex_wdata;
    in_e.load    = load_i;
    in_e.store   = store_i;
    in_e.addr    = mem_addr_i;
    in_e.wr_data = mem_write_data_i;
    in_e.len     = mem_length_i;
    in_e.sgn     = mem_signed_i;
  end

  // Emptied entries are zeroed so a bubble never presents a write or memory op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q   <= '0;
      s_q   <= '0;
      count <= '0;
    end else if (flush) begin
      h_q   <= '0;
      s_q   <= '0;
      count <= '0;
    end else if (rdy) begin
      case (count)
        2'd0: begin
          if (acc) begin
            h_q   <= in_e;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (acc && deq) begin
            h_q <= in_e;
          end else if (acc) begin
            s_q   <= in_e;
            count <= 2'd2;
          end else if (deq) begin
            h_q   <= '0;
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (deq) begin
            h_q   <= s_q;
            s_q   <= '0;
            count <= 2'd1;
          end
        end
        default: begin
          h_q   <= '0;
          s_q   <= '0;
          count <= '0;
        end
      endcase
    end
  end

  assign out_valid        = h_q.valid;
  assign mem_wd           = h_q.wd;
  assign mem_wreg         = h_q.wreg;
  assign mem_wdata        = h_q.wdata;
  assign load_o           = h_q.load;
  assign store_o          = h_q.store;
  assign mem_addr_o       = h_q.addr;
  assign mem_write_data_o = h_q.wr_data;
  assign mem_length_o     = h_q.len;
  assign mem_signed_o     = h_q.sgn;

  // fwd1 (skid) is the younger entry; the consumer gives it precedence on a match.
  assign fwd0_valid = h_q.valid && h_q.wreg && (h_q.wd != '0);
  assign fwd0_wd    = h_q.wd;
  assign fwd0_data  = h_q.wdata;
  assign fwd0_load  = h_q.valid && h_q.load;
  assign fwd1_valid = s_q.valid && s_q.wreg && (s_q.wd != '0);
  assign fwd1_wd    = s_q.wd;
  assign fwd1_data  = s_q.wdata;
  assign fwd1_load  = s_q.valid && s_q.load;

endmodule

// File: tb/tb_ex_mem_buf.sv
module tb_ex_mem_buf;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        load_i;
  logic        store_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_write_data_i;
  logic [2:0]  mem_length_i;
  logic        mem_signed_i;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        load_o;
  logic        store_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_write_data_o;
  logic [2:0]  mem_length_o;
  logic        mem_signed_o;
  logic [1:0]  count;
  logic        fwd0_valid;
  logic [4:0]  fwd0_wd;
  logic [31:0] fwd0_data;
  logic        fwd0_load;
  logic        fwd1_valid;
  logic [4:0]  fwd1_wd;
  logic [31:0] fwd1_data;
  logic        fwd1_load;

  int total;
  int bad;

  ex_mem_buf #(.DATA_W(32), .REG_ADDR_W(5), .LEN_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .load_i(load_i), .store_i(store_i),
    .mem_addr_i(mem_addr_i), .mem_write_data_i(mem_write_data_i),
    .mem_length_i(mem_length_i), .mem_signed_i(mem_signed_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .load_o(load_o), .store_o(store_o),
    .mem_addr_o(mem_addr_o), .mem_write_data_o(mem_write_data_o),
    .mem_length_o(mem_length_o), .mem_signed_o(mem_signed_o),
    .count(count),
    .fwd0_valid(fwd0_valid), .fwd0_wd(fwd0_wd), .fwd0_data(fwd0_data), .fwd0_load(fwd0_load),
    .fwd1_valid(fwd1_valid), .fwd1_wd(fwd1_wd), .fwd1_data(fwd1_data), .fwd1_load(fwd1_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver only; all comparisons live in the test tasks.
  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic ld, input logic st);
    in_valid         = v;
    ex_wd            = wd;
    ex_wreg          = wreg;
    ex_wdata         = wdata;
    load_i           = ld;
    store_i          = st;
    mem_addr_i       = 32'h1000 + {27'd0, wd};
    mem_write_data_i = 32'hD000 + {27'd0, wd};
    mem_length_i     = wd[2:0];
    mem_signed_i     = wd[0];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || mem_wd !== 5'd0 || fwd0_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got count=%0d ov=%0b wd=%0d f0v=%0b exp 0 0 0 0",
               count, out_valid, mem_wd, fwd0_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_pass_through;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i > 1) begin
        total++;
        if (mem_wd !== 5'(i - 1) || mem_wdata !== 32'h10 + 32'(i - 2) || count !== 2'd1 ||
            out_valid !== 1'b1 || mem_addr_o !== 32'h1000 + 32'(i - 1) ||
            mem_write_data_o !== 32'hD000 + 32'(i - 1) || mem_length_o !== 3'(i - 1) ||
            mem_signed_o !== 1'((i - 1) % 2) || store_o !== 1'((i - 1) % 2)) begin
          bad++;
          $display("FAIL pass_through_%0d got wd=%0d data=%0h cnt=%0d ov=%0b addr=%0h exp wd=%0d data=%0h cnt=1",
                   i - 1, mem_wd, mem_wdata, count, out_valid, mem_addr_o, i - 1, 32'h10 + i - 2);
        end
      end
      if (i <= 4) drive(1'b1, 5'(i), 1'b1, 32'h10 + 32'(i - 1), 1'b0, 1'((i) % 2));
      else drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || mem_wreg !== 1'b0 || store_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_bubble got cnt=%0d ov=%0b wreg=%0b st=%0b exp 0 0 0 0",
               count, out_valid, mem_wreg, store_o);
    end
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (count !== 2'd2 || in_ready !== 1'b0 || mem_wd !== 5'd5 || fwd1_wd !== 5'd6) begin
      bad++;
      $display("FAIL bp_full got cnt=%0d ir=%0b wd=%0d f1wd=%0d exp 2 0 5 6",
               count, in_ready, mem_wd, fwd1_wd);
    end
    drive(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (count !== 2'd2 || mem_wd !== 5'd5 || fwd1_wd !== 5'd6) begin
      bad++;
      $display("FAIL bp_reject got cnt=%0d wd=%0d f1wd=%0d exp 2 5 6", count, mem_wd, fwd1_wd);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (mem_wd !== 5'd6 || mem_wdata !== 32'h66 || count !== 2'd1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_second got wd=%0d data=%0h cnt=%0d ir=%0b exp 6 66 1 1",
               mem_wd, mem_wdata, count, in_ready);
    end
    @(negedge clk);
    total++;
    if (mem_wd !== 5'd7 || mem_wdata !== 32'h77 || count !== 2'd1) begin
      bad++;
      $display("FAIL bp_late_accept got wd=%0d data=%0h cnt=%0d exp 7 77 1", mem_wd, mem_wdata, count);
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'h88, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'd10, 1'b1, 32'hAA, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || mem_wreg !== 1'b0 || load_o !== 1'b0 ||
        fwd1_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear got cnt=%0d ov=%0b wreg=%0b ld=%0b f1v=%0b exp 0 0 0 0 0",
               count, out_valid, mem_wreg, load_o, fwd1_valid);
    end
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || mem_wd !== 5'd0) begin
      bad++;
      $display("FAIL flush_discard got cnt=%0d ov=%0b wd=%0d exp 0 0 0", count, out_valid, mem_wd);
    end
  endtask

  task automatic test_rdy_pause;
    out_ready = 1'b0;
    drive(1'b1, 5'd11, 1'b1, 32'hB1, 1'b0, 1'b0);
    @(negedge clk);
    rdy = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 32'hC2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (count !== 2'd1 || mem_wd !== 5'd11 || mem_wdata !== 32'hB1 || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL rdy_hold_%0d got cnt=%0d wd=%0d data=%0h ir=%0b exp 1 11 b1 0",
                 k, count, mem_wd, mem_wdata, in_ready);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    total++;
    if (count !== 2'd1 || mem_wd !== 5'd12 || mem_wdata !== 32'hC2) begin
      bad++;
      $display("FAIL rdy_resume got cnt=%0d wd=%0d data=%0h exp 1 12 c2", count, mem_wd, mem_wdata);
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_forwarding;
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b1, 32'hABCD, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (fwd1_valid !== 1'b1 || fwd1_data !== 32'hABCD || fwd1_wd !== 5'd3 || fwd1_load !== 1'b0 ||
        fwd0_load !== 1'b1 || fwd0_valid !== 1'b1 || fwd0_wd !== 5'd3) begin
      bad++;
      $display("FAIL fwd_load_alu got f1v=%0b f1d=%0h f1wd=%0d f1l=%0b f0l=%0b f0v=%0b exp 1 abcd 3 0 1 1",
               fwd1_valid, fwd1_data, fwd1_wd, fwd1_load, fwd0_load, fwd0_valid);
    end
    flush = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, 5'd0, 1'b1, 32'h1234, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (fwd0_valid !== 1'b0 || out_valid !== 1'b1 || fwd0_data !== 32'h1234) begin
      bad++;
      $display("FAIL fwd_x0 got f0v=%0b ov=%0b f0d=%0h exp 0 1 1234", fwd0_valid, out_valid, fwd0_data);
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 5'd20, 1'b1, 32'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd21, 1'b1, 32'h21, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    total++;
    if (count !== 2'd2) begin
      bad++;
      $display("FAIL mid_prefill got cnt=%0d exp 2", count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || mem_wd !== 5'd0 || mem_wdata !== 32'd0 ||
        fwd0_valid !== 1'b0 || fwd1_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_reset got cnt=%0d ov=%0b wd=%0d f0v=%0b f1v=%0b exp all 0",
               count, out_valid, mem_wd, fwd0_valid, fwd1_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || count !== 2'd0) begin
      bad++;
      $display("FAIL mid_release got ir=%0b cnt=%0d exp 1 0", in_ready, count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    test_reset;
    test_pass_through;
    test_back_pressure;
    test_flush;
    test_rdy_pause;
    test_forwarding;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
